// File: rtl/event_dispatch_arbiter_pkg.sv
// Shared types and constants for the event dispatch arbiter slice.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package event_dispatch_arbiter_pkg;

  // Dispatcher control states.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ARB  = 3'd1,
    ST_WAIT = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  // Event address is {row, col}.
  localparam int EVT_ROW_WIDTH  = 8;
  localparam int EVT_COL_WIDTH  = 8;
  localparam int EVT_ADDR_WIDTH = EVT_ROW_WIDTH + EVT_COL_WIDTH;

  // Delivered-event counter and response timeout counter widths.
  localparam int CNT_WIDTH = 16;
  localparam int TMO_WIDTH = 8;

  // Index width for an N-entry one-hot vector; never below one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/event_dispatch_arbiter_rr_arbiter.sv
// Round-robin picker: first request above last_grant, wrapping at NUM_PE.
// Latency: purely combinational.
// Backpressure: none; grant is only a suggestion until the caller registers it.
module event_dispatch_arbiter_rr_arbiter
  import event_dispatch_arbiter_pkg::*;
#(
  parameter int NUM_PE = 4,
  parameter int IDX_W  = idx_width(NUM_PE)
) (
  input  logic [NUM_PE-1:0] req,
  input  logic [IDX_W-1:0]  last_grant,
  output logic [NUM_PE-1:0] grant_oh,
  output logic [IDX_W-1:0]  grant_idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  // Walk candidates last_grant+1 .. last_grant+NUM_PE; the first set request wins.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int off = 1; off <= NUM_PE; off++) begin
      cand = IDX_W'((int'(last_grant) + off) % NUM_PE);
      if (!found && req[cand]) begin
        found          = 1'b1;
        grant_oh[cand] = 1'b1;
        grant_idx      = cand;
      end
    end
  end

endmodule

// File: rtl/event_dispatch_arbiter.sv
// Shares one request/response event source among NUM_PE engines, round-robin, one fetch in flight.
// Latency: pe_req seen in ARB at T -> src_req T+1 -> src_valid T+2 -> pe_valid T+3.
// Backpressure: engines hold pe_req until their pe_valid; a missing src_valid trips a sticky timeout.
module event_dispatch_arbiter
  import event_dispatch_arbiter_pkg::*;
#(
  parameter int NUM_PE       = 4,
  parameter int DATA_WIDTH   = 4,
  parameter int ADDR_WIDTH   = EVT_ADDR_WIDTH,
  parameter int TOTAL_EVENTS = 1000,
  parameter int TIMEOUT      = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [NUM_PE-1:0]     pe_req,
  output logic [NUM_PE-1:0]     pe_valid,
  output logic [DATA_WIDTH-1:0] pe_value,
  output logic [ADDR_WIDTH-1:0] pe_addr,
  output logic                  src_req,
  input  logic                  src_valid,
  input  logic [DATA_WIDTH-1:0] src_value,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout_err,
  output logic [CNT_WIDTH-1:0]  event_count
);

  localparam int IDX_W = idx_width(NUM_PE);

  state_e                state, state_nx;
  logic [IDX_W-1:0]      grant, grant_nx;
  logic [IDX_W-1:0]      last_grant, last_grant_nx;
  logic [TMO_WIDTH-1:0]  tmo, tmo_nx;
  logic [CNT_WIDTH-1:0]  count_nx, count_inc;
  logic [NUM_PE-1:0]     pe_valid_nx;
  logic [DATA_WIDTH-1:0] pe_value_nx;
  logic [ADDR_WIDTH-1:0] pe_addr_nx;
  logic                  src_req_nx, busy_nx, done_nx, err_nx;
  logic [NUM_PE-1:0]     arb_oh;
  logic [IDX_W-1:0]      arb_idx;

  event_dispatch_arbiter_rr_arbiter #(
    .NUM_PE (NUM_PE),
    .IDX_W  (IDX_W)
  ) u_rr (
    .req        (pe_req),
    .last_grant (last_grant),
    .grant_oh   (arb_oh),
    .grant_idx  (arb_idx)
  );

  // Next-state and next-output decode; every output is registered from these values.
  always_comb begin
    state_nx      = state;
    grant_nx      = grant;
    last_grant_nx = last_grant;
    tmo_nx        = tmo;
    count_nx      = event_count;
    count_inc     = event_count + CNT_WIDTH'(1);
    src_req_nx    = 1'b0;
    pe_valid_nx   = '0;
    pe_value_nx   = pe_value;
    pe_addr_nx    = pe_addr;
    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_nx = ST_ARB;
          count_nx = '0;
        end
      end
      ST_ARB: begin
        if (|arb_oh) begin
          grant_nx   = arb_idx;
          src_req_nx = 1'b1;
          tmo_nx     = '0;
          state_nx   = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (src_valid) begin
          pe_value_nx        = src_value;
          pe_addr_nx         = src_addr;
          pe_valid_nx[grant] = 1'b1;
          count_nx           = count_inc;
          last_grant_nx      = grant;
          state_nx = (count_inc == CNT_WIDTH'(TOTAL_EVENTS)) ? ST_DONE : ST_ARB;
        end else if (tmo == TMO_WIDTH'(TIMEOUT)) begin
          state_nx = ST_ERR;
        end else begin
          tmo_nx = tmo + TMO_WIDTH'(1);
        end
      end
      default: state_nx = ST_IDLE;
    endcase
    busy_nx = (state_nx == ST_ARB) || (state_nx == ST_WAIT);
    done_nx = (state_nx == ST_DONE);
    err_nx  = (state_nx == ST_ERR);
  end

  // State and output registers; reset discards any in-flight fetch and re-arms PE0 as first winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      grant       <= '0;
      last_grant  <= IDX_W'(NUM_PE - 1);
      tmo         <= '0;
      event_count <= '0;
      src_req     <= 1'b0;
      pe_valid    <= '0;
      pe_value    <= '0;
      pe_addr     <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_nx;
      grant       <= grant_nx;
      last_grant  <= last_grant_nx;
      tmo         <= tmo_nx;
      event_count <= count_nx;
      src_req     <= src_req_nx;
      pe_valid    <= pe_valid_nx;
      pe_value    <= pe_value_nx;
      pe_addr     <= pe_addr_nx;
      busy        <= busy_nx;
      done        <= done_nx;
      timeout_err <= err_nx;
    end
  end

endmodule

// File: tb/tb_event_dispatch_arbiter.sv
// Bench for event_dispatch_arbiter: directed scenarios plus a randomized run against a
// transaction-level model (round-robin pick from requests, source reply queue, event count).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_event_dispatch_arbiter;

  localparam int NPE = 4;
  localparam int TOT = 6;
  localparam int TMO = 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  pe_req = '0;
  logic [3:0]  pe_valid;
  logic [3:0]  pe_value;
  logic [15:0] pe_addr;
  logic        src_req;
  logic        src_valid = 1'b0;
  logic [3:0]  src_value = '0;
  logic [15:0] src_addr = '0;
  logic        busy, done, timeout_err;
  logic [15:0] event_count;

  always #5 clk = ~clk;

  event_dispatch_arbiter #(
    .NUM_PE(NPE), .DATA_WIDTH(4), .ADDR_WIDTH(16), .TOTAL_EVENTS(TOT), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pe_req(pe_req),
    .pe_valid(pe_valid), .pe_value(pe_value), .pe_addr(pe_addr),
    .src_req(src_req), .src_valid(src_valid), .src_value(src_value), .src_addr(src_addr),
    .busy(busy), .done(done), .timeout_err(timeout_err), .event_count(event_count)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int          lg_model = NPE - 1;
  bit          waiting = 0;
  int          cur_w = 0;
  int          pend = 0;
  int          src_lat = 1;
  bit          src_auto = 1;
  bit          src_fixed = 0;
  logic [3:0]  fix_val = '0;
  logic [15:0] fix_addr = '0;
  logic [3:0]  exp_pv = '0;
  logic [3:0]  exp_val = '0;
  logic [15:0] exp_addr = '0;
  int          exp_cnt = 0;
  int          src_req_cnt = 0;
  logic [3:0]  req_sampled = '0;

  function automatic int rr_pick(input logic [3:0] r, input int lg);
    int c;
    for (int k = 1; k <= NPE; k++) begin
      c = (lg + k) % NPE;
      if (r[c[1:0]]) return c;
    end
    return 0;
  endfunction

  // One clock: advance to falling edge, update model from what the DUT saw, act as the source.
  task automatic cycle();
    @(negedge clk);
    req_sampled = pe_req;
    exp_pv = '0;
    if (src_valid && waiting) begin
      exp_pv   = 4'(1 << cur_w);
      exp_val  = src_value;
      exp_addr = src_addr;
      exp_cnt++;
      lg_model = cur_w;
      waiting  = 0;
    end
    src_valid = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        src_valid = 1'b1;
        src_value = src_fixed ? fix_val  : 4'($urandom);
        src_addr  = src_fixed ? fix_addr : 16'($urandom);
      end
    end
    if (src_req === 1'b1) begin
      src_req_cnt++;
      cur_w   = rr_pick(req_sampled, lg_model);
      waiting = 1;
      if (src_auto) pend = src_lat;
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; pe_req = '0; src_valid = 1'b0;
    pend = 0; waiting = 0; lg_model = NPE - 1; exp_cnt = 0; exp_pv = '0;
    src_auto = 1; src_fixed = 0; src_lat = 1; src_req_cnt = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic do_start();
    start = 1'b1;
    cycle();
    start = 1'b0;
    exp_cnt = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pe_valid, pe_value, pe_addr, src_req, busy, done, timeout_err, event_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got pv=%b val=%h addr=%h sreq=%b busy=%b done=%b err=%b cnt=%0d required all 0",
               pe_valid, pe_value, pe_addr, src_req, busy, done, timeout_err, event_count);
    end
    apply_reset();
    pe_req = 4'hF;
    src_valid = 1'b1;
    repeat (3) cycle();
    checks++;
    if ({busy, src_req, pe_valid, event_count} !== '0) begin
      errors++;
      $display("FAIL idle_ignores_inputs got busy=%b sreq=%b pv=%b cnt=%0d required 0", busy, src_req, pe_valid, event_count);
    end
    pe_req = '0;
  endtask

  task automatic test_single();
    apply_reset();
    do_start();
    checks++;
    if (busy !== 1'b1 || event_count !== 16'd0) begin
      errors++; $display("FAIL single_start got busy=%b cnt=%0d required busy=1 cnt=0", busy, event_count);
    end
    pe_req = 4'b0010; src_fixed = 1; fix_val = 4'hA; fix_addr = 16'h0203;
    cycle();
    checks++;
    if (src_req !== 1'b1) begin errors++; $display("FAIL single_src_req_t1 got %b required 1", src_req); end
    cycle();
    checks++;
    if (src_req !== 1'b0 || pe_valid !== 4'b0000) begin
      errors++; $display("FAIL single_t2 got sreq=%b pv=%b required 0 0000", src_req, pe_valid);
    end
    cycle();
    checks++;
    if (pe_valid !== 4'b0010 || pe_value !== 4'hA || pe_addr !== 16'h0203 || event_count !== 16'd1) begin
      errors++; $display("FAIL single_deliver got pv=%b val=%h addr=%h cnt=%0d required 0010 a 0203 1",
                         pe_valid, pe_value, pe_addr, event_count);
    end
    pe_req = '0; src_fixed = 0;
    cycle();
    checks++;
    if (pe_valid !== 4'b0000 || pe_value !== 4'hA) begin
      errors++; $display("FAIL single_pulse_hold got pv=%b val=%h required 0000 a", pe_valid, pe_value);
    end
  endtask

  task automatic test_round_robin();
    int order[5] = '{0, 1, 2, 3, 0};
    int n = 0;
    apply_reset();
    do_start();
    pe_req = 4'hF;
    for (int c = 0; c < 200 && n < 5; c++) begin
      cycle();
      checks++;
      if (pe_valid !== exp_pv) begin errors++; $display("FAIL rr_model got %b required %b", pe_valid, exp_pv); end
      if (exp_pv != 0) begin
        checks++;
        if (pe_valid !== 4'(1 << order[n]) || src_req_cnt != n + 1) begin
          errors++; $display("FAIL rr_order[%0d] got pv=%b sreqs=%0d required %b sreqs=%0d",
                             n, pe_valid, src_req_cnt, 4'(1 << order[n]), n + 1);
        end
        n++;
      end
    end
    checks++;
    if (n != 5) begin errors++; $display("FAIL rr_budget got %0d deliveries required 5", n); end
    pe_req = '0;
  endtask

  task automatic test_done();
    int n = 0;
    apply_reset();
    do_start();
    pe_req = 4'hF;
    for (int c = 0; c < 200 && n < TOT; c++) begin
      cycle();
      if (pe_valid !== 4'b0000) begin
        n++;
        checks++;
        if (done !== (n == TOT) || busy !== (n != TOT) || event_count !== 16'(n)) begin
          errors++; $display("FAIL done_flag at %0d got done=%b busy=%b cnt=%0d", n, done, busy, event_count);
        end
      end
    end
    checks++;
    if (n != TOT) begin errors++; $display("FAIL done_budget got %0d deliveries required %0d", n, TOT); end
    for (int c = 0; c < 6; c++) begin
      cycle();
      checks++;
      if (src_req !== 1'b0 || done !== 1'b1 || pe_valid !== 4'b0000) begin
        errors++; $display("FAIL done_quiet got sreq=%b done=%b pv=%b required 0 1 0000", src_req, done, pe_valid);
      end
    end
    checks++;
    if (src_req_cnt != TOT) begin errors++; $display("FAIL done_src_reqs got %0d required %0d", src_req_cnt, TOT); end
    pe_req = '0;
  endtask

  task automatic test_timeout();
    bit seen = 0;
    do_start();
    checks++;
    if (done !== 1'b0 || event_count !== 16'd0 || busy !== 1'b1) begin
      errors++; $display("FAIL restart_from_done got done=%b cnt=%0d busy=%b required 0 0 1", done, event_count, busy);
    end
    src_auto = 0;
    pe_req = 4'b0001;
    for (int c = 0; c < 10 && !seen; c++) begin
      cycle();
      if (src_req === 1'b1) seen = 1;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL tmo_no_src_req got none required one"); end
    for (int k = 1; k <= TMO + 1; k++) begin
      cycle();
      checks++;
      if (k <= TMO && (timeout_err !== 1'b0 || busy !== 1'b1)) begin
        errors++; $display("FAIL tmo_early k=%0d got err=%b busy=%b required 0 1", k, timeout_err, busy);
      end else if (k == TMO + 1 && (timeout_err !== 1'b1 || done !== 1'b0 || busy !== 1'b0)) begin
        errors++; $display("FAIL tmo_fire got err=%b done=%b busy=%b required 1 0 0", timeout_err, done, busy);
      end
    end
    waiting = 0;
    repeat (3) begin
      cycle();
      checks++;
      if (timeout_err !== 1'b1 || src_req !== 1'b0) begin
        errors++; $display("FAIL tmo_sticky got err=%b sreq=%b required 1 0", timeout_err, src_req);
      end
    end
    src_auto = 1;
    do_start();
    checks++;
    if (timeout_err !== 1'b0 || event_count !== 16'd0 || busy !== 1'b1) begin
      errors++; $display("FAIL tmo_recover got err=%b cnt=%0d busy=%b required 0 0 1", timeout_err, event_count, busy);
    end
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      cycle();
      if (exp_pv != 0) begin
        seen = 1;
        checks++;
        if (pe_valid !== exp_pv || event_count !== 16'd1) begin
          errors++; $display("FAIL tmo_recover_deliver got pv=%b cnt=%0d required %b 1", pe_valid, event_count, exp_pv);
        end
      end
    end
    pe_req = '0;
  endtask

  task automatic test_withdraw();
    bit seen = 0;
    pe_req = 4'b0100;
    for (int c = 0; c < 10 && !seen; c++) begin
      cycle();
      if (src_req === 1'b1) seen = 1;
    end
    pe_req = '0;
    seen = 0;
    for (int c = 0; c < 6 && !seen; c++) begin
      cycle();
      if (pe_valid !== 4'b0000 || exp_pv != 0) begin
        seen = 1;
        checks++;
        if (pe_valid !== 4'b0100 || pe_valid !== exp_pv || pe_value !== exp_val || pe_addr !== exp_addr) begin
          errors++; $display("FAIL withdraw_deliver got pv=%b val=%h addr=%h required 0100 %h %h",
                             pe_valid, pe_value, pe_addr, exp_val, exp_addr);
        end
      end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL withdraw_budget got no pe_valid required pulse on PE2"); end
    src_valid = 1'b1; src_value = ~exp_val; src_addr = ~exp_addr;
    repeat (2) begin
      cycle();
      checks++;
      if (pe_valid !== 4'b0000 || event_count !== 16'(exp_cnt) || pe_value !== exp_val || src_req !== 1'b0) begin
        errors++; $display("FAIL stray_valid got pv=%b cnt=%0d val=%h sreq=%b required 0000 %0d %h 0",
                           pe_valid, event_count, pe_value, src_req, exp_cnt, exp_val);
      end
    end
  endtask

  task automatic test_random();
    int dlv = 0;
    bit restart;
    for (int c = 0; c < 800; c++) begin
      pe_req  = 4'($urandom);
      src_lat = $urandom_range(1, 3);
      restart = (done === 1'b1);
      start   = restart || ($urandom_range(0, 15) == 0);
      cycle();
      start = 1'b0;
      if (restart) exp_cnt = 0;
      checks++;
      if (pe_valid !== exp_pv || event_count !== 16'(exp_cnt) || done !== (exp_cnt == TOT) || timeout_err !== 1'b0) begin
        errors++; $display("FAIL rand c=%0d got pv=%b cnt=%0d done=%b err=%b required %b %0d %b 0",
                           c, pe_valid, event_count, done, timeout_err, exp_pv, exp_cnt, exp_cnt == TOT);
      end
      if (exp_pv != 0) begin
        dlv++;
        checks++;
        if (pe_value !== exp_val || pe_addr !== exp_addr) begin
          errors++; $display("FAIL rand_data got %h/%h required %h/%h", pe_value, pe_addr, exp_val, exp_addr);
        end
      end
    end
    checks++;
    if (dlv < 50) begin errors++; $display("FAIL rand_progress got %0d deliveries required >= 50", dlv); end
    pe_req = '0;
  endtask

  task automatic test_reset_mid();
    bit seen = 0;
    apply_reset();
    do_start();
    src_auto = 0;
    pe_req = 4'hF;
    for (int c = 0; c < 10 && !seen; c++) begin
      cycle();
      if (src_req === 1'b1) seen = 1;
    end
    cycle();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({pe_valid, pe_value, pe_addr, src_req, busy, done, timeout_err, event_count} !== '0) begin
      errors++; $display("FAIL async_reset got busy=%b cnt=%0d pv=%b sreq=%b required all 0",
                         busy, event_count, pe_valid, src_req);
    end
    @(negedge clk);
    rst_n = 1'b1;
    waiting = 0; pend = 0; lg_model = NPE - 1; exp_cnt = 0; src_auto = 1;
    do_start();
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      cycle();
      if (pe_valid !== 4'b0000) begin
        seen = 1;
        checks++;
        if (pe_valid !== 4'b0001 || event_count !== 16'd1) begin
          errors++; $display("FAIL post_reset_grant got pv=%b cnt=%0d required 0001 1", pe_valid, event_count);
        end
      end
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL post_reset_budget got no delivery required one"); end
    pe_req = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_done();
    test_timeout();
    test_withdraw();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no completion required finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
